// File: rtl/dac_pkg.sv
// Shared constants, state type and period helper for the DAC pin driver.
package dac_pkg;

  localparam logic [9:0] DAC_MIDSCALE = 10'h200;
  localparam int         PN9_TAP_A    = 8;
  localparam int         PN9_TAP_B    = 4;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2
  } dac_state_t;

  // Sample period in clocks: a divider of 0 behaves like 1, so the
  // shortest period is two clocks (one low phase, one high phase).
  function automatic int unsigned eff_period(input int unsigned div);
    return (div == 0) ? 32'd2 : div + 32'd1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Show-ahead sample FIFO: the head entry is always visible on pop_data, so a
// pop and the use of its data happen in the same clock.
module dac_sample_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the registered level, so a pop never makes room
  // for a push in the same cycle.
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push & ~full & ~flush;
  assign pop_ok   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  // Sample storage; no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_pn_driver.sv
// DAC pin driver: power sequencing, sample pacing and FIFO/PN9 sample source.
module dac_pn_driver
  import dac_pkg::*;
#(
  parameter int         DATA_W     = 10,
  parameter int         FIFO_DEPTH = 16,
  parameter int         DIV_W      = 8,
  parameter int         WAKE_CYC   = 64,
  parameter logic [8:0] PN_SEED    = 9'h1FF,
  parameter logic       PIN_MD     = 1'b0,
  parameter logic       CLK_MD     = 1'b0
) (
  input  logic                            sys_clk_pin,
  input  logic                            sys_rst_pin,
  input  logic                            ctrl_enable,
  input  logic                            ctrl_pwrdn,
  input  logic                            ctrl_mode,
  input  logic                            ctrl_format,
  input  logic [DIV_W-1:0]                ctrl_div,
  input  logic                            fifo_flush,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underrun_flag,
  input  logic                            underrun_clr,
  output logic                            busy,
  output logic [DATA_W-1:0]               S_Data,
  output logic                            S_DCLKIO,
  output logic                            S_Format,
  output logic                            S_PWRDN,
  output logic                            S_PinMD,
  output logic                            S_ClkMD
);

  localparam int                PER_W    = DIV_W + 1;
  localparam int                WAKE_W   = $clog2(WAKE_CYC + 1);
  localparam logic [DATA_W-1:0] MID      = DATA_W'(DAC_MIDSCALE);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  dac_state_t        state;
  dac_state_t        state_next;
  logic [8:0]        lfsr;
  logic [PER_W-1:0]  cnt;
  logic [PER_W-1:0]  period;
  logic [WAKE_W-1:0] wake_cnt;
  logic              tick;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              underrun_set;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] pn_sample;
  logic [DATA_W-1:0] next_sample;

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk_pin),
    .rst_n     (sys_rst_pin),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready     = ~fifo_full;
  assign S_PinMD      = PIN_MD;
  assign S_ClkMD      = CLK_MD;
  assign pn_sample    = {lfsr, {(DATA_W-9){1'b0}}};
  assign next_sample  = (ctrl_mode ? pn_sample : fifo_data) ^ (ctrl_format ? MSB_MASK : '0);
  assign fifo_pop     = tick & ~ctrl_mode & ~fifo_empty;
  assign underrun_set = tick & ~ctrl_mode & fifo_empty;

  // Next state and tick strobe. tick marks the edge on which a new sample is
  // launched; the last WAKE cycle launches the first sample so it appears on
  // the pins exactly as RUN begins (cnt==0).
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    if (!ctrl_enable || ctrl_pwrdn) begin
      state_next = OFF;
    end else begin
      case (state)
        OFF:  state_next = WAKE;
        WAKE: begin
          if (wake_cnt == WAKE_W'(WAKE_CYC - 1)) begin
            state_next = RUN;
            tick       = 1'b1;
          end
        end
        RUN:     tick = (cnt == period - 1'b1);
        default: state_next = OFF;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) state <= OFF;
    else              state <= state_next;
  end

  // Pin registers, period divider, wake timer and PN9 generator.
  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      S_Data   <= MID;
      S_DCLKIO <= 1'b0;
      S_PWRDN  <= 1'b1;
      S_Format <= 1'b0;
      busy     <= 1'b0;
      lfsr     <= PN_SEED;
      cnt      <= '0;
      period   <= PER_W'(2);
      wake_cnt <= '0;
    end else begin
      busy     <= (state_next != OFF);
      S_PWRDN  <= (state_next == OFF);
      wake_cnt <= (state == WAKE && state_next == WAKE) ? wake_cnt + 1'b1 : '0;
      if (state == OFF || tick) S_Format <= ctrl_format;

      if (state_next == OFF) begin
        S_Data   <= MID;
        S_DCLKIO <= 1'b0;
        lfsr     <= PN_SEED;
        cnt      <= '0;
      end else if (tick) begin
        // New period: the divider is re-sampled only here.
        S_DCLKIO <= 1'b0;
        cnt      <= '0;
        period   <= PER_W'(eff_period(32'(ctrl_div)));
        if (ctrl_mode) begin
          S_Data <= next_sample;
          lfsr   <= {lfsr[7:0], lfsr[PN9_TAP_A] ^ lfsr[PN9_TAP_B]};
        end else if (!fifo_empty) begin
          S_Data <= next_sample;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == (period >> 1)) S_DCLKIO <= 1'b1;
      end
    end
  end

  // Sticky underrun; a new underrun wins over a simultaneous clear.
  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin)      underrun_flag <= 1'b0;
    else if (underrun_set) underrun_flag <= 1'b1;
    else if (underrun_clr) underrun_flag <= 1'b0;
  end

endmodule

// File: tb/tb_dac_pn_driver.sv
// Directed bench for dac_pn_driver: PN pacing, FIFO playback/underrun,
// FIFO full handling, output format, power-down and asynchronous reset.
module tb_dac_pn_driver;

  logic       sys_clk_pin = 1'b0;
  logic       sys_rst_pin = 1'b0;
  logic       ctrl_enable = 1'b0;
  logic       ctrl_pwrdn  = 1'b0;
  logic       ctrl_mode   = 1'b0;
  logic       ctrl_format = 1'b0;
  logic [7:0] ctrl_div    = 8'd0;
  logic       fifo_flush  = 1'b0;
  logic [9:0] wr_data     = 10'd0;
  logic       wr_valid    = 1'b0;
  logic       wr_ready;
  logic [4:0] fifo_level;
  logic       underrun_flag;
  logic       underrun_clr = 1'b0;
  logic       busy;
  logic [9:0] S_Data;
  logic       S_DCLKIO;
  logic       S_Format;
  logic       S_PWRDN;
  logic       S_PinMD;
  logic       S_ClkMD;

  int errors = 0;
  int checks = 0;

  dac_pn_driver dut (
    .sys_clk_pin   (sys_clk_pin),
    .sys_rst_pin   (sys_rst_pin),
    .ctrl_enable   (ctrl_enable),
    .ctrl_pwrdn    (ctrl_pwrdn),
    .ctrl_mode     (ctrl_mode),
    .ctrl_format   (ctrl_format),
    .ctrl_div      (ctrl_div),
    .fifo_flush    (fifo_flush),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .fifo_level    (fifo_level),
    .underrun_flag (underrun_flag),
    .underrun_clr  (underrun_clr),
    .busy          (busy),
    .S_Data        (S_Data),
    .S_DCLKIO      (S_DCLKIO),
    .S_Format      (S_Format),
    .S_PWRDN       (S_PWRDN),
    .S_PinMD       (S_PinMD),
    .S_ClkMD       (S_ClkMD)
  );

  always #5 sys_clk_pin = ~sys_clk_pin;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk_pin);
    #1;
  endtask

  task automatic write_sample(input logic [9:0] v);
    wr_data  = v;
    wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    $display("write %h level=%0d ready=%0b", v, fifo_level, wr_ready);
  endtask

  task automatic test_reset;
    step(2);
    checks++; if (S_Data !== 10'h200) begin errors++; $display("FAIL reset_data got %h want 200", S_Data); end
    checks++; if (S_DCLKIO !== 1'b0) begin errors++; $display("FAIL reset_dclk got %b want 0", S_DCLKIO); end
    checks++; if (S_PWRDN !== 1'b1) begin errors++; $display("FAIL reset_pwrdn got %b want 1", S_PWRDN); end
    checks++; if (S_Format !== 1'b0) begin errors++; $display("FAIL reset_format got %b want 0", S_Format); end
    checks++; if (underrun_flag !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun_flag); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({S_PinMD, S_ClkMD} !== 2'b00) begin errors++; $display("FAIL reset_md got %b want 00", {S_PinMD, S_ClkMD}); end
    sys_rst_pin = 1'b1;
    step(2);
    checks++; if (S_PWRDN !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_off got pwrdn=%b busy=%b want 1 0", S_PWRDN, busy); end
    $display("reset done");
  endtask

  task automatic test_pn_sequence;
    logic [8:0] m_lfsr;
    logic [9:0] exp;
    logic [9:0] first;
    m_lfsr = 9'h1FF;
    first  = 10'h000;
    ctrl_mode = 1'b1; ctrl_div = 8'd3; ctrl_format = 1'b0; ctrl_enable = 1'b1;
    step(1);
    checks++; if (S_PWRDN !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wake_entry got pwrdn=%b busy=%b want 0 1", S_PWRDN, busy); end
    step(63);
    checks++; if (S_Data !== 10'h200) begin errors++; $display("FAIL wake_hold got %h want 200", S_Data); end
    step(1);
    for (int i = 0; i < 512; i++) begin
      exp = {m_lfsr, 1'b0};
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
      if (i == 0) first = S_Data;
      checks++; if (S_Data !== exp) begin errors++; $display("FAIL pn_tick%0d got %h want %h", i, S_Data, exp); end
      checks++; if (S_DCLKIO !== 1'b0) begin errors++; $display("FAIL pn_dclk_low%0d got %b want 0", i, S_DCLKIO); end
      if (i == 0) begin
        checks++; if (S_Data !== 10'h3FE) begin errors++; $display("FAIL pn_first got %h want 3fe", S_Data); end
      end
      if (i == 1) begin
        checks++; if (S_Data !== 10'h3FC) begin errors++; $display("FAIL pn_second got %h want 3fc", S_Data); end
      end
      if (i == 511) begin
        checks++; if (S_Data !== first) begin errors++; $display("FAIL pn_repeat got %h want %h", S_Data, first); end
      end
      if (i < 511) begin
        step(1);
        checks++; if (S_DCLKIO !== 1'b0) begin errors++; $display("FAIL pn_dclk_c1_%0d got %b want 0", i, S_DCLKIO); end
        step(1);
        checks++; if (S_DCLKIO !== 1'b1) begin errors++; $display("FAIL pn_dclk_rise%0d got %b want 1", i, S_DCLKIO); end
        step(2);
      end
    end
    $display("pn 512 ticks checked");
  endtask

  task automatic test_pwrdn;
    step(2);
    ctrl_pwrdn = 1'b1;
    step(1);
    checks++; if (S_PWRDN !== 1'b1) begin errors++; $display("FAIL pd_pwrdn got %b want 1", S_PWRDN); end
    checks++; if (S_Data !== 10'h200) begin errors++; $display("FAIL pd_data got %h want 200", S_Data); end
    checks++; if (S_DCLKIO !== 1'b0) begin errors++; $display("FAIL pd_dclk got %b want 0", S_DCLKIO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pd_busy got %b want 0", busy); end
    ctrl_pwrdn = 1'b0;
    step(65);
    checks++; if (S_Data !== 10'h3FE) begin errors++; $display("FAIL pd_restart got %h want 3fe", S_Data); end
    step(4);
    checks++; if (S_Data !== 10'h3FC) begin errors++; $display("FAIL pd_restart2 got %h want 3fc", S_Data); end
    ctrl_enable = 1'b0;
    step(1);
    $display("pwrdn/restart done");
  endtask

  task automatic test_fifo_underrun;
    ctrl_mode = 1'b0; ctrl_div = 8'd0;
    write_sample(10'h100);
    write_sample(10'h2AA);
    write_sample(10'h055);
    checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL prefill_level got %0d want 3", fifo_level); end
    ctrl_enable = 1'b1;
    step(65);
    checks++; if (S_Data !== 10'h100) begin errors++; $display("FAIL fifo_s0 got %h want 100", S_Data); end
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL fifo_lvl_after_pop got %0d want 2", fifo_level); end
    step(1);
    checks++; if (S_DCLKIO !== 1'b1) begin errors++; $display("FAIL fifo_dclk_p2 got %b want 1", S_DCLKIO); end
    step(1);
    checks++; if (S_Data !== 10'h2AA) begin errors++; $display("FAIL fifo_s1 got %h want 2aa", S_Data); end
    step(2);
    checks++; if (S_Data !== 10'h055 || underrun_flag !== 1'b0) begin errors++; $display("FAIL fifo_s2 got %h uf=%b want 055 0", S_Data, underrun_flag); end
    step(2);
    checks++; if (S_Data !== 10'h055) begin errors++; $display("FAIL underrun_hold got %h want 055", S_Data); end
    checks++; if (underrun_flag !== 1'b1) begin errors++; $display("FAIL underrun_set got %b want 1", underrun_flag); end
    step(1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (underrun_flag !== 1'b1) begin errors++; $display("FAIL underrun_set_wins got %b want 1", underrun_flag); end
    ctrl_enable = 1'b0;
    step(1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (underrun_flag !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", underrun_flag); end
    $display("fifo playback/underrun done");
  endtask

  task automatic test_back_to_back_full;
    fifo_flush = 1'b1; step(1); fifo_flush = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_data  = 10'h010 + 10'(i);
      wr_valid = 1'b1;
      step(1);
      $display("write %h level=%0d ready=%0b", wr_data, fifo_level, wr_ready);
      if (i == 14) begin
        checks++; if (wr_ready !== 1'b1 || fifo_level !== 5'd15) begin errors++; $display("FAIL fill15 got ready=%b lvl=%0d want 1 15", wr_ready, fifo_level); end
      end
      if (i == 15) begin
        checks++; if (wr_ready !== 1'b0 || fifo_level !== 5'd16) begin errors++; $display("FAIL fill16 got ready=%b lvl=%0d want 0 16", wr_ready, fifo_level); end
      end
      if (i == 16) begin
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill17_drop got lvl=%0d want 16", fifo_level); end
      end
    end
    wr_valid = 1'b0;
    ctrl_enable = 1'b1;
    step(65);
    for (int i = 0; i < 16; i++) begin
      checks++; if (S_Data !== 10'h010 + 10'(i)) begin errors++; $display("FAIL drain%0d got %h want %h", i, S_Data, 10'h010 + 10'(i)); end
      step(2);
    end
    checks++; if (S_Data !== 10'h01F || underrun_flag !== 1'b1) begin errors++; $display("FAIL drain_end got %h uf=%b want 01f 1", S_Data, underrun_flag); end
    ctrl_enable = 1'b0;
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    $display("full/drop/drain done");
  endtask

  task automatic test_format;
    write_sample(10'h200);
    write_sample(10'h3FF);
    ctrl_format = 1'b1; ctrl_mode = 1'b0; ctrl_div = 8'd0; ctrl_enable = 1'b1;
    step(1);
    checks++; if (S_Format !== 1'b1) begin errors++; $display("FAIL fmt_pin got %b want 1", S_Format); end
    step(64);
    checks++; if (S_Data !== 10'h000) begin errors++; $display("FAIL fmt_200 got %h want 000", S_Data); end
    step(2);
    checks++; if (S_Data !== 10'h1FF) begin errors++; $display("FAIL fmt_3ff got %h want 1ff", S_Data); end
    ctrl_enable = 1'b0;
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    $display("format done");
  endtask

  task automatic test_async_reset;
    write_sample(10'h123);
    ctrl_mode = 1'b1; ctrl_div = 8'd3; ctrl_format = 1'b1; ctrl_enable = 1'b1;
    step(65);
    checks++; if (S_Data !== 10'h1FE) begin errors++; $display("FAIL pn_fmt got %h want 1fe", S_Data); end
    step(2);
    checks++; if (S_DCLKIO !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL pre_rst got dclk=%b lvl=%0d want 1 1", S_DCLKIO, fifo_level); end
    #2;
    sys_rst_pin = 1'b0;
    #1;
    checks++; if (S_Data !== 10'h200) begin errors++; $display("FAIL arst_data got %h want 200", S_Data); end
    checks++; if (S_DCLKIO !== 1'b0) begin errors++; $display("FAIL arst_dclk got %b want 0", S_DCLKIO); end
    checks++; if (S_PWRDN !== 1'b1) begin errors++; $display("FAIL arst_pwrdn got %b want 1", S_PWRDN); end
    checks++; if (S_Format !== 1'b0) begin errors++; $display("FAIL arst_format got %b want 0", S_Format); end
    checks++; if (fifo_level !== 5'd0 || wr_ready !== 1'b1) begin errors++; $display("FAIL arst_fifo got lvl=%0d ready=%b want 0 1", fifo_level, wr_ready); end
    checks++; if (busy !== 1'b0 || underrun_flag !== 1'b0) begin errors++; $display("FAIL arst_busy got busy=%b uf=%b want 0 0", busy, underrun_flag); end
    ctrl_enable = 1'b0;
    sys_rst_pin = 1'b1;
    step(2);
    checks++; if (S_PWRDN !== 1'b1 || S_Data !== 10'h200) begin errors++; $display("FAIL post_rst got pwrdn=%b data=%h want 1 200", S_PWRDN, S_Data); end
    $display("async reset done");
  endtask

  initial begin
    #1;
    test_reset();
    test_pn_sequence();
    test_pwrdn();
    test_fifo_underrun();
    test_back_to_back_full();
    test_format();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
